// File: rtl/tt_hs_pkg.sv
// Shared types and constants for the REQ/ACK handshake register file.
package tt_hs_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CMD_ACK   = 2'd1,
    WAIT_DATA = 2'd2,
    DATA_ACK  = 2'd3
  } state_t;

  // uio bit positions
  localparam int REQ_BIT  = 0;
  localparam int ACK_BIT  = 1;
  localparam int ERR_BIT  = 2;
  localparam int PAR_BIT  = 3;
  localparam int ADDR_LSB = 4;

  // command byte fields
  localparam int CMD_W_BIT    = 7;
  localparam int CMD_RSV_MSB  = 6;
  localparam int CMD_RSV_LSB  = 4;
  localparam int CMD_ADDR_MSB = 3;
  localparam int CMD_ADDR_LSB = 0;

  localparam logic [7:0] UIO_OE_VAL = 8'hFE;

endpackage

// File: rtl/tt_hs_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module tt_hs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // shift the raw input through the flop chain
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/tt_um_hs_regfile.sv
// Tiny Tapeout responder: 4-phase REQ/ACK byte handshake into an NREGS x 8 register file.
module tt_um_hs_regfile
  import tt_hs_pkg::*;
#(
  parameter int NREGS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t          r_state;
  logic [7:0]      r_regs [0:NREGS-1];
  logic [7:0]      r_uo;
  logic            r_par;
  logic            r_ack;
  logic            r_err;
  logic [3:0]      r_last;
  logic [AW-1:0]   r_addr;
  logic            r_go_data;

  logic            w_req_s;
  logic            w_cmd_w;
  logic [3:0]      w_cmd_addr;
  logic            w_bad;
  logic [7:0]      w_rd_data;
  logic            w_unused;

  tt_hs_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_d    (uio_in[REQ_BIT]),
    .o_q    (w_req_s)
  );

  assign w_cmd_w    = ui_in[CMD_W_BIT];
  assign w_cmd_addr = ui_in[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign w_bad      = (ui_in[CMD_RSV_MSB:CMD_RSV_LSB] != 3'b000) ||
                      ({1'b0, w_cmd_addr} >= 5'(NREGS));
  assign w_rd_data  = r_regs[w_cmd_addr[AW-1:0]];
  assign w_unused   = &{1'b0, uio_in[7:1]};

  // handshake FSM, register file and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_uo      <= '0;
      r_par     <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_last    <= '0;
      r_addr    <= '0;
      r_go_data <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (!ena) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_s) begin
            if (w_bad) begin
              r_err     <= 1'b1;
              r_go_data <= 1'b0;
              if (!w_cmd_w) begin
                r_uo  <= '0;
                r_par <= 1'b0;
              end
            end else begin
              r_err     <= 1'b0;
              r_go_data <= w_cmd_w;
              if (w_cmd_w) begin
                r_addr <= w_cmd_addr[AW-1:0];
              end else begin
                r_uo   <= w_rd_data;
                r_par  <= ^w_rd_data;
                r_last <= w_cmd_addr;
              end
            end
            r_ack   <= 1'b1;
            r_state <= CMD_ACK;
          end
        end
        CMD_ACK: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= r_go_data ? WAIT_DATA : IDLE;
          end
        end
        WAIT_DATA: begin
          if (w_req_s) begin
            r_regs[r_addr] <= ui_in;
            r_uo           <= ui_in;
            r_par          <= ^ui_in;
            r_last         <= 4'(r_addr);
            r_ack          <= 1'b1;
            r_state        <= DATA_ACK;
          end
        end
        DATA_ACK: begin
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // pack status onto the bidirectional pins
  always_comb begin
    uio_out                        = '0;
    uio_out[ACK_BIT]               = r_ack;
    uio_out[ERR_BIT]               = r_err;
    uio_out[PAR_BIT]               = r_par;
    uio_out[ADDR_LSB +: 4]         = r_last;
  end

  assign uo_out = r_uo;
  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_hs_regfile.sv
// Self-checking bench for tt_um_hs_regfile with a transaction-level reference model.
module tb_tt_um_hs_regfile;

  localparam int NREGS = 8;
  localparam int SS    = 2;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_hs_regfile #(.NREGS(NREGS), .SYNC_STAGES(SS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [7:0] m_regs [NREGS];
  logic [7:0] m_uo;
  logic       m_err;
  logic [3:0] m_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_uo = 8'h00; m_err = 1'b0; m_last = 4'h0;
  endtask

  // wait (bounded) until ACK reaches lvl; returns edges taken
  task automatic wait_ack(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (uio_out[1] !== lvl && n < 20);
    if (uio_out[1] !== lvl) check("ack_timeout", uio_out[1], lvl);
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_uo"},   uo_out,       m_uo);
    check({tag, "_err"},  uio_out[2],   m_err);
    check({tag, "_last"}, uio_out[7:4], m_last);
    check({tag, "_par"},  uio_out[3],   ^m_uo);
    check({tag, "_b0"},   uio_out[0],   1'b0);
    check({tag, "_oe"},   uio_oe,       8'hFE);
  endtask

  task automatic raise(input logic [7:0] b, input logic chk_lat);
    int n;
    ui_in = b;
    uio_in[0] = 1'b1;
    wait_ack(1'b1, n);
    if (chk_lat) check("ack_rise_lat", n, SS + 1);
  endtask

  task automatic release_req(input logic chk_lat);
    int n;
    uio_in[0] = 1'b0;
    wait_ack(1'b0, n);
    if (chk_lat) check("ack_fall_lat", n, SS + 1);
  endtask

  // apply a command to the model; returns 1 when a data phase follows
  function automatic logic model_cmd(input logic [7:0] cmd);
    logic bad;
    int   a;
    a   = int'(cmd[3:0]);
    bad = (cmd[6:4] != 3'b000) || (a >= NREGS);
    if (bad) begin
      m_err = 1'b1;
      if (!cmd[7]) m_uo = 8'h00;
      return 1'b0;
    end
    m_err = 1'b0;
    if (cmd[7]) return 1'b1;
    m_uo   = m_regs[a];
    m_last = cmd[3:0];
    return 1'b0;
  endfunction

  task automatic xact(input logic [7:0] cmd, input logic [7:0] data, input logic chk_lat);
    logic has_data;
    has_data = model_cmd(cmd);
    raise(cmd, chk_lat);
    check_outs("cmd");
    release_req(chk_lat);
    if (has_data) begin
      m_regs[cmd[3:0]] = data;
      m_uo   = data;
      m_last = cmd[3:0];
      raise(data, chk_lat);
      check_outs("data");
      release_req(1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    model_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_oe",  uio_oe,  8'hFE);
    check("rst_uo",  uo_out,  8'h00);
    check("rst_uio", uio_out, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NREGS; i++) xact(8'(i), 8'h00, 1'b1);

    // write 3 then read it back
    xact(8'h83, 8'hA5, 1'b1);
    xact(8'h03, 8'h00, 1'b1);
    check("rd3_par", uio_out[3], 1'b0);

    // bad address write, then a good read clears ERR
    xact(8'h8A, 8'h00, 1'b1);
    check("bad_err", m_err, 1'b1);
    xact(8'h00, 8'h00, 1'b1);
    xact(8'h03, 8'h00, 1'b1);

    // reserved bits set on a read
    xact(8'h13, 8'h00, 1'b1);

    // full sweep
    for (int i = 0; i < NREGS; i++) xact(8'h80 | 8'(i), 8'h10 + 8'(i), 1'b1);
    for (int i = NREGS - 1; i >= 0; i--) xact(8'(i), 8'h00, 1'b1);

    // reset while waiting for the data byte
    begin
      logic dummy;
      dummy = model_cmd(8'h85);
      raise(8'h85, 1'b1);
      check_outs("abort_cmd");
      release_req(1'b1);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rst_abort_ack", uio_out[1], 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      xact(8'h05, 8'h00, 1'b1);
    end

    // drop ena during CMD_ACK
    xact(8'h82, 8'h5C, 1'b1);
    begin
      logic dummy;
      int   n;
      dummy = model_cmd(8'h02);
      raise(8'h02, 1'b1);
      ena = 1'b0;
      @(posedge clk); @(negedge clk);
      check("ena_ack", uio_out[1], 1'b0);
      check("ena_uo",  uo_out, m_uo);
      uio_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      // REQ high while disabled starts nothing
      ui_in = 8'h01; uio_in[0] = 1'b1;
      repeat (8) @(negedge clk);
      check("ena_noack", uio_out[1], 1'b0);
      check("ena_hold_uo", uo_out, m_uo);
      // re-enable with REQ still high: new command
      dummy = model_cmd(8'h01);
      ena = 1'b1;
      wait_ack(1'b1, n);
      check_outs("reena");
      release_req(1'b1);
      xact(8'h02, 8'h00, 1'b1);
    end

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic [7:0] cmd;
      if ($urandom_range(0, 4) != 0)
        cmd = {1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, NREGS - 1))};
      else
        cmd = 8'($urandom);
      xact(cmd, 8'($urandom), 1'b1);
    end
    for (int i = 0; i < NREGS; i++) xact(8'(i), 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_um_hs_regfile.md
Name: tt_um_hs_regfile

Overview:
- Tiny Tapeout user project; the responder end of a 4-phase REQ/ACK byte handshake on the standard pin set.
- The cocotb bench (or an off-chip MCU) is the initiator. It presents command/data bytes on ui_in and toggles REQ.
- The block acknowledges each byte and executes register writes/reads into an NREGS x 8-bit register file.
- Read data returns on uo_out; status returns on uio_out.

Parameters:
- NREGS, 8, number of 8-bit registers (legal 1..16).
- SYNC_STAGES, 2, flops in the REQ synchronizer (legal 2..3).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- ena  in  1  design selected; 0 forces FSM to IDLE
- ui_in  in  8  command byte / write data byte
- uo_out  out  8  read data (registered)
- uio_in  in  8  bit0 = REQ from initiator; bits 7:1 ignored
- uio_out  out  8  bit0=0, bit1=ACK, bit2=ERR, bit3=parity(uo_out), bits7:4=last valid address
- uio_oe  out  8  constant 8'hFE (bit0 input, bits7:1 output)

Behaviour:
- Reset (rst_n=0 at a clk edge): all synchronizer flops 0, state IDLE, all regs 8'h00, uo_out 8'h00, ACK 0, ERR 0, parity 0, last address 0. uio_oe is always 8'hFE, including during reset.
- REQ passes through the SYNC_STAGES synchronizer to give req_s. The FSM acts only on req_s.
- ACK is a registered state output. With REQ asserted before edge k, ACK rises after edge k+SYNC_STAGES (3rd edge at default). The same latency applies to ACK falling after REQ falls.
- Command byte fields: ui_in[7] = W (1 write, 0 read); ui_in[6:4] must be 000; ui_in[3:0] = addr.
- A command is bad if ui_in[6:4]≠0 or addr≥NREGS.
- ui_in is sampled in the cycle req_s is first seen high. The initiator holds ui_in stable from REQ rise until it sees ACK.
- FSM states:
  - IDLE: on req_s=1, decode and latch ui_in.
    - Read, good: uo_out←reg[addr]; ERR←0; last addr←addr → CMD_ACK.
    - Write, good: ERR←0; latch addr → CMD_ACK.
    - Bad: ERR←1; uo_out←00 for a read, unchanged for a write → CMD_ACK.
  - CMD_ACK: ACK=1. On req_s=0, go to WAIT_DATA for a good write, else IDLE.
  - WAIT_DATA: ACK=0. On req_s=1: reg[addr]←ui_in; uo_out←ui_in (echo); last addr←addr → DATA_ACK.
  - DATA_ACK: ACK=1. On req_s=0 → IDLE.
- A bad write skips the data phase. The initiator sees ERR=1 with ACK and does not send data.
- ERR persists until the next accepted command byte.
- Parity: uio_out[3] = XOR of uo_out bits, registered in the same cycle as uo_out (always consistent).
- ena=0: at the next edge the state goes to IDLE and ACK goes to 0. Registers and uo_out are retained, and no transaction starts while ena=0.
  - If ena returns while REQ is still high, that is treated as a new command.
- Reset mid-transaction behaves as full reset. A write is never partially applied: the register updates only in the WAIT_DATA→DATA_ACK transition.
- REQ dropping early in WAIT_DATA is not possible by protocol (REQ is already low there). Spurious REQ glitches shorter than one clock may be missed; this is legal.

Decomposition:
- Package tt_hs_pkg holds:
  - state enum (IDLE, CMD_ACK, WAIT_DATA, DATA_ACK);
  - uio bit-position constants (REQ_BIT=0, ACK_BIT=1, ERR_BIT=2, PAR_BIT=3, ADDR_LSB=4);
  - command field constants (CMD_W_BIT=7, CMD_RSV_MSB/LSB=6/4, CMD_ADDR_MSB/LSB=3/0);
  - UIO_OE_VAL=8'hFE.
- Sub-module tt_hs_sync: parameterised SYNC_STAGES synchronizer with synchronous active-low reset. It is instantiated once for REQ.

Test Plan:
- Reset: rst_n=0 for 10 cycles → uo_out=00, uio_out=00, uio_oe=FE. Read every address → 00.
- Write then read:
  - cmd 8'h83, then data 8'hA5 → ACK pulses twice, ERR=0, uio_out[7:4]=3, uo_out=A5.
  - Read cmd 8'h03 → uo_out=A5, parity bit=0, ACK after 3 edges.
- Bad address: cmd 8'h8A (NREGS=8) → ACK with ERR=1, no data phase; reg contents unchanged. The next good read cmd 8'h00 clears ERR.
- Reserved bits: cmd 8'h13 → ERR=1, uo_out=00.
- Full sweep: write value 8'h10+i to addresses 0..7, then read back in reverse order. Each uo_out matches, and parity equals the XOR of its bits.
- Abort cases:
  - Assert rst_n=0 while in WAIT_DATA after cmd 8'h85 → reg5 stays 00 and ACK goes to 0.
  - Drop ena while in CMD_ACK → ACK=0 next edge; registers retained.
